serial_adder: RTL and testbench

//  - Bit-serial adder with carry-in/out; the additive counterpart of the team's clocked borrow subtractor.
//  - Adds two WIDTH-bit unsigned operands, one bit per clock, using a single full-adder cell.
//  - Start/Busy/Done handshake; the result is held stable until the next accepted Start.

---
 rtl/adder_pkg.sv | 12 +
 rtl/full_adder_cell.sv | 18 +
 rtl/serial_adder.sv | 152 +++++++++++++++
 tb/tb_serial_adder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_e : FSM encoding for serial_adder (S_IDLE, S_RUN, S_DONE).
// No ports; imported by serial_adder.
package adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit unsigned operands plus carry-in, one bit per clock,
// LSB first, through a single full_adder_cell.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   in1, in2       : operands, [0:WIDTH-1] (index WIDTH-1 is the LSB)
//   CarryIn        : carry into the LSB
//   Start          : request, sampled only in S_IDLE or S_DONE
//   Busy           : high while the operation runs
//   Done           : one-cycle pulse; Sum/CarryOut valid from here until the next accept
//   Sum, CarryOut  : result and carry out of the MSB
//   Overflow       : two's-complement overflow, only with SERIAL_ADDER_OVERFLOW_EN defined
// Configuration macro: SERIAL_ADDER_OVERFLOW_EN.
module serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:WIDTH-1] in1,
  input  logic [0:WIDTH-1] in2,
  input  logic             CarryIn,
  input  logic             Start,
  output logic             Busy,
  output logic             Done,
  output logic [0:WIDTH-1] Sum,
  output logic             CarryOut
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             Overflow
`endif
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [0:WIDTH-1] a_q, a_d;
  logic [0:WIDTH-1] b_q, b_d;
  logic [0:WIDTH-1] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic [CntW-1:0]  bit_idx;
  logic             fa_s;
  logic             fa_cout;

  // The counter walks from the LSB (index WIDTH-1) towards the MSB (index 0).
  assign bit_idx = CntLast - cnt_q;

  full_adder_cell u_fa (
    .a    (a_q[bit_idx]),
    .b    (b_q[bit_idx]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          a_d     = in1;
          b_d     = in2;
          carry_d = CarryIn;
          sum_d   = '0;
          cout_d  = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
          ovf_d   = 1'b0;
`endif
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d[bit_idx] = fa_s;
        carry_d        = fa_cout;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
          // On the MSB step carry_q is the carry into the MSB.
          ovf_d   = carry_q ^ fa_cout;
`endif
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Sum      = sum_q;
  assign CarryOut = cout_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=4) using an expected-result scoreboard.
module tb_serial_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [0:W-1] in1 = '0;
  logic [0:W-1] in2 = '0;
  logic         carry_in = 1'b0;
  logic         start = 1'b0;
  logic         busy;
  logic         done;
  logic [0:W-1] sum;
  logic         carry_out;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic         overflow;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in1      (in1),
    .in2      (in2),
    .CarryIn  (carry_in),
    .Start    (start),
    .Busy     (busy),
    .Done     (done),
    .Sum      (sum),
    .CarryOut (carry_out)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    .Overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W:0] res;
    logic       ovf;
    int         dcyc;
  } sb_item_t;

  sb_item_t   exp_q[$];
  sb_item_t   mon_it;
  logic [W:0] last_res;
  int         cyc = 0;
  int         done_count = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  function automatic sb_item_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic c, input int dcyc);
    sb_item_t   it;
    logic [W:0] low;
    it.res  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    low     = {2'b00, a[W-2:0]} + {2'b00, b[W-2:0]} + {{W{1'b0}}, c};
    it.ovf  = low[W-1] ^ it.res[W];
    it.dcyc = dcyc;
    return it;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every Done pulse must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (done) begin
      done_count++;
      if (exp_q.size() == 0) begin
        check_eq("extra_done", 32'd1, 32'd0);
      end else begin
        mon_it = exp_q.pop_front();
        check_eq("result", {27'd0, carry_out, sum}, {27'd0, mon_it.res});
        check_eq("latency", cyc, mon_it.dcyc);
        check_eq("busy_at_done", {31'd0, busy}, 32'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        check_eq("overflow", {31'd0, overflow}, {31'd0, mon_it.ovf});
`endif
        last_res = mon_it.res;
      end
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(negedge clk);
    in1      = a;
    in2      = b;
    carry_in = c;
    start    = 1'b1;
    exp_q.push_back(model(a, b, c, cyc + 1 + W));
    @(posedge clk);
    #1;
    start    = 1'b0;
    // Scramble inputs: only the latched operands may matter.
    in1      = W'($urandom);
    in2      = W'($urandom);
    carry_in = 1'($urandom);
  endtask

  task automatic wait_done_n(input int target, input string tag);
    for (int i = 0; i < 3 * W + 10 && done_count < target; i++) begin
      @(negedge clk);
      #1;
    end
    check_eq(tag, done_count, target);
  endtask

  initial begin
    int base;
    int d1;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_sum", {28'd0, sum}, 32'd0);
    check_eq("rst_cout", {31'd0, carry_out}, 32'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // 0011 + 0101 -> 1000, carry 0; also Busy during run and result hold
    base = done_count;
    start_op(4'b0011, 4'b0101, 1'b0);
    check_eq("busy_run", {31'd0, busy}, 32'd1);
    wait_done_n(base + 1, "done_op1");
    repeat (2) @(negedge clk);
    #1;
    check_eq("hold_result", {27'd0, carry_out, sum}, {27'd0, last_res});
    check_eq("idle_busy", {31'd0, busy}, 32'd0);

    // 1111 + 0001 + 1 -> 0001, carry 1, no overflow
    base = done_count;
    start_op(4'b1111, 4'b0001, 1'b1);
    wait_done_n(base + 1, "done_op2");

    // Start pulsed mid-run with new operands must be ignored
    base = done_count;
    start_op(4'b0110, 4'b0011, 1'b0);
    @(negedge clk);
    in1   = 4'b1111;
    in2   = 4'b1111;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done_n(base + 1, "done_midrun");
    repeat (W + 3) @(negedge clk);
    #1;
    check_eq("no_extra_done", done_count, base + 1);

    // Start held high through Done: second op accepted in the Done cycle
    base = done_count;
    @(negedge clk);
    in1      = 4'b1001;
    in2      = 4'b0111;
    carry_in = 1'b0;
    start    = 1'b1;
    exp_q.push_back(model(4'b1001, 4'b0111, 1'b0, cyc + 1 + W));
    d1 = cyc + 1 + W;
    @(posedge clk);
    #1;
    in1      = 4'b0101;
    in2      = 4'b0100;
    carry_in = 1'b1;
    exp_q.push_back(model(4'b0101, 4'b0100, 1'b1, d1 + 1 + W));
    while (cyc < d1) @(negedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done_n(base + 2, "done_b2b");

    // Reset during the second RUN cycle aborts the operation
    start_op(4'b0011, 4'b0101, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_sum", {28'd0, sum}, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    base = done_count;
    start_op(4'b0111, 4'b0001, 1'b0);
    wait_done_n(base + 1, "done_after_abort");

    // Exhaustive sweep
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        for (int c = 0; c < 2; c++) begin
          base = done_count;
          start_op(W'(a), W'(b), 1'(c));
          wait_done_n(base + 1, "done_sweep");
        end
      end
    end

    check_eq("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
